spram_rr_arbiter: RTL
=====================

// Module: spram_rr_arbiter
// PURPOSE
//   Two-port round-robin arbiter and sequencer in front of one single-port RAM.
//   Each port issues a read or write request; the block shares the RAM between them.
//   It latches the winning command, drives the RAM's en/wr/address/in pins, captures
//   the registered read data, and returns it to the requester.
//   The arbiter sits between two masters and the RAM, which has a 1-cycle registered
//   read and drives out to 0 whenever en=0.
// PARAMETERS
//   AW     4   address width, matching the RAM address port
//   DW     8   data width, matching the RAM in/out ports
//   DEPTH  4   number of implemented RAM words; used only by SPRAM_ADDR_CHECK_EN
// PORTS
//   clk       in   1   single clock; all state updates on posedge
//   rst       in   1   synchronous, active-high reset
//   req0/1    in   1   request from port 0/1; hold with wr/addr/wdata until gnt
//   wr0/1     in   1   1 = write, 0 = read
//   addr0/1   in   AW  word address
//   wdata0/1  in   DW  write data
//   gnt0/1    out  1   one-cycle pulse: command accepted, request may drop
//   rvalid0/1 out  1   one-cycle pulse: rdata0/1 valid
//   rdata0/1  out  DW  read data register; holds its value until the next read on that port
//   err0/1    out  1   one-cycle pulse: command rejected (feature only, else 0)
//   ram_en    out  1   to RAM en
//   ram_wr    out  1   to RAM wr
//   ram_addr  out  AW  to RAM address
//   ram_din   out  DW  to RAM in
//   ram_dout  in   DW  from RAM out
// BEHAVIOUR
//   - FSM states:
//     - IDLE: RAM pins all 0.
//     - ACCESS: ram_en=1; ram_wr/addr/din come from the latched command.
//     - RDATA: ram_en=0; waits for the read data.
//   - IDLE, some req: pick a winner; latch its wr/addr/wdata and port id; go to ACCESS.
//     The winner's gnt is high during the ACCESS cycle.
//   - Winner selection:
//     - Only one req high: that port wins.
//     - Both high: the port named by pointer ptr wins.
//     - After every grant, ptr <= the other port, giving strict alternation under contention.
//   - ACCESS, write: the RAM writes at the end of this cycle; next state is IDLE.
//   - ACCESS, read: next state is RDATA. ram_dout is valid during RDATA.
//     At the end of RDATA: rdataN <= ram_dout, rvalidN <= 1 for one cycle; next state is IDLE.
//   - Latency, with req seen in IDLE at cycle N:
//     - gnt at N+1 (the ACCESS cycle).
//     - write lands at the end of N+1.
//     - rvalid at N+3.
//     - next acceptance at N+2 after a write, N+3 after a read.
//   - Requests are sampled only in IDLE. A latched command always completes, even if
//     req drops. A req that is still high after its gnt counts as a new request.
//   - Reset: state=IDLE, ptr=0, all gnt/rvalid/err=0, rdata0/1=0, latched command=0.
//   - rst high in any state forces ram_en=0 combinationally, so no RAM access occurs in
//     a reset cycle. An in-flight read is dropped with no rvalid.
//   - Addresses pass through unchecked; any AW-bit value goes to the RAM.
//   - No arithmetic beyond the 1-bit ptr toggle.
// CONFIGURATION
//   SPRAM_ADDR_CHECK_EN defined:
//     - In IDLE, a winning command with addr >= DEPTH still gets gnt and ptr advances.
//     - The FSM stays in IDLE and the RAM pins stay 0.
//     - errN pulses in the same cycle as gntN. No rvalid is issued and no write occurs.
//   SPRAM_ADDR_CHECK_EN undefined: no range check; err0/err1 tied to 0.
// TESTING
//   1. rst 2 cycles -> all outputs 0, ram_en=0, rdata0=rdata1=0.
//   2. Port0 writes addr 2 = 8'hA5, then reads addr 2:
//      -> gnt0 at N+1, ram_en=1/ram_wr=1/ram_addr=2/ram_din=A5 at N+1.
//      -> rvalid0 with rdata0=8'hA5 three cycles after the read is seen.
//   3. req0 and req1 high together with reads, from reset:
//      -> port0 granted first, port1 next.
//      -> under continuous contention, gnt strictly alternates 0,1,0,1.
//   4. Port1 reads addr 3 and rst pulses during RDATA:
//      -> no rvalid1, rdata1=0, FSM in IDLE, ram_en=0 in the reset cycle.
//   5. Port0 drops req0 the cycle after gnt0 on a read:
//      -> read still completes with rvalid0; port1 then wins the next contended grant.
//   6. With SPRAM_ADDR_CHECK_EN, DEPTH=4, port0 writes addr 9:
//      -> gnt0 and err0 in the same cycle, ram_en stays 0.
//      -> a later read of every addr 0..3 returns the previously written data unchanged.

Source files
------------

// File: rtl/spram_rr_arbiter.sv
// ============================================================================
// Module      : spram_rr_arbiter
// Description : Two-port round-robin arbiter and sequencer in front of one
//               single-port RAM (1-cycle registered read, dout=0 when en=0).
//               Optional feature macro: SPRAM_ADDR_CHECK_EN (reject addr>=DEPTH
//               with a gnt+err pulse and no RAM access).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spram_rr_arbiter #(
    parameter int          AW    = 4,
    parameter int          DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDATA  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ptr_q;
    logic          port_q;
    logic          cmd_wr_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_din_q;
    logic          gnt0_q, gnt1_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          err0_q, err1_q;

    logic          w_any;
    logic          w_sel1;
    logic          w_win_wr;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_din;
    logic          w_bad;
    logic          w_accept;

    // Winner selection: a lone requester wins, otherwise the pointer decides
    always_comb begin
        w_any      = req0 | req1;
        w_sel1     = req1 & (~req0 | ptr_q);
        w_win_wr   = w_sel1 ? wr1    : wr0;
        w_win_addr = w_sel1 ? addr1  : addr0;
        w_win_din  = w_sel1 ? wdata1 : wdata0;
        w_accept   = (state_q == S_IDLE) && w_any;
    end

`ifdef SPRAM_ADDR_CHECK_EN
    // Out-of-range addresses are granted but rejected without touching the RAM
    assign w_bad = (32'(w_win_addr) >= DEPTH);
`else
    // DEPTH only matters to the range check; reference it so it is not dangling
    logic w_unused_depth;
    assign w_unused_depth = (DEPTH == 0);
    assign w_bad          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_any && !w_bad) state_d = S_ACCESS;
            S_ACCESS: state_d = cmd_wr_q ? S_IDLE : S_RDATA;
            S_RDATA:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // RAM pin drive: active only in ACCESS, and never while reset is asserted
    always_comb begin
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if ((state_q == S_ACCESS) && !rst) begin
            ram_en   = 1'b1;
            ram_wr   = cmd_wr_q;
            ram_addr = cmd_addr_q;
            ram_din  = cmd_din_q;
        end
    end

    // Command latch, pointer, grant/error pulses and read-data return
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            port_q     <= 1'b0;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_din_q  <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            gnt0_q    <= w_accept && !w_sel1;
            gnt1_q    <= w_accept &&  w_sel1;
            err0_q    <= w_accept && !w_sel1 && w_bad;
            err1_q    <= w_accept &&  w_sel1 && w_bad;
            rvalid0_q <= (state_q == S_RDATA) && !port_q;
            rvalid1_q <= (state_q == S_RDATA) &&  port_q;
            if (w_accept) begin
                ptr_q <= ~w_sel1;
                if (!w_bad) begin
                    port_q     <= w_sel1;
                    cmd_wr_q   <= w_win_wr;
                    cmd_addr_q <= w_win_addr;
                    cmd_din_q  <= w_win_din;
                end
            end
            if (state_q == S_RDATA) begin
                if (port_q) rdata1_q <= ram_dout;
                else        rdata0_q <= ram_dout;
            end
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;

endmodule

`default_nettype wire
